// File: rtl/whackmole_pkg.sv
// Shared whack-a-mole definitions: lane count, debounce window, mole vector
// type and the arming FSM encoding used by the input conditioner.
package whackmole_pkg;

    localparam int N_MOLES       = 18;
    localparam int DEBOUNCE_20MS = 1_000_000;

    typedef logic [N_MOLES-1:0] mole_vec_t;

    typedef enum logic {
        ARMING = 1'b0,
        RUN    = 1'b1
    } arm_state_t;

    // Settle time after reset: fill the synchroniser, then one full debounce run.
    function automatic int arm_window(input int sync_stages, input int debounce_cycles);
        return sync_stages + debounce_cycles;
    endfunction

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch-side bundle between the board switches / game logic and the
// conditioner; slave is the conditioner, master is whoever drives the switches.
interface switch_conditioner_if #(
    parameter int N_SW = whackmole_pkg::N_MOLES
) ();

    logic [N_SW-1:0] sw_raw;
    logic            clear;
    logic [N_SW-1:0] sw_stable;
    logic [N_SW-1:0] sw_toggle;
    logic [N_SW-1:0] hit_latch;
    logic            armed;

    modport master (
        output sw_raw,
        output clear,
        input  sw_stable,
        input  sw_toggle,
        input  hit_latch,
        input  armed
    );

    modport slave (
        input  sw_raw,
        input  clear,
        output sw_stable,
        output sw_toggle,
        output hit_latch,
        output armed
    );

endinterface

// File: rtl/switch_conditioner_debounce_lane.sv
// One switch lane: multi-flop synchroniser, restart-on-bounce debounce counter
// and the accepted-level flop; exposes the next accepted level and a change flag.
module debounce_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable_next,
    output logic change
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_next_s;
    logic                   stable_r;
    logic                   stable_next_s;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Debounce decision: any cycle that agrees with the accepted level restarts the count.
    always_comb begin
        cnt_next_s    = '0;
        stable_next_s = stable_r;
        if (sync_s != stable_r) begin
            if (cnt_r == CNT_LAST) begin
                stable_next_s = sync_s;
                cnt_next_s    = '0;
            end else begin
                cnt_next_s    = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = '0;
        end
    end

    // Synchroniser chain, debounce counter and accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r   <= '0;
            cnt_r    <= '0;
            stable_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], raw};
            cnt_r    <= cnt_next_s;
            stable_r <= stable_next_s;
        end
    end

    assign stable_next = stable_next_s;
    assign change      = stable_next_s ^ stable_r;

endmodule

// File: rtl/switch_conditioner.sv
// Switch front end: per-lane debounce, post-reset arming window, toggle pulses
// and per-round sticky hit latch cleared by the round boundary pulse.
module switch_conditioner
    import whackmole_pkg::*;
#(
    parameter int N_SW            = N_MOLES,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS
) (
    input  logic                clk,
    input  logic                reset,
    switch_conditioner_if.slave bus
);

    localparam int               ARM_WINDOW = arm_window(SYNC_STAGES, DEBOUNCE_CYCLES);
    localparam int               ARM_W      = $clog2(ARM_WINDOW + 1);
    localparam logic [ARM_W-1:0] ARM_LAST   = ARM_W'(ARM_WINDOW - 1);
    localparam logic [ARM_W-1:0] ARM_ONE    = ARM_W'(1);

    logic [N_SW-1:0]  stable_next_s;
    logic [N_SW-1:0]  change_s;
    logic [N_SW-1:0]  toggle_next_s;
    logic [N_SW-1:0]  hit_next_s;
    logic [N_SW-1:0]  sw_stable_r;
    logic [N_SW-1:0]  toggle_r;
    logic [N_SW-1:0]  hit_r;
    arm_state_t       state_r;
    logic [ARM_W-1:0] arm_cnt_r;
    logic             armed_r;

    genvar g;
    generate
        for (g = 0; g < N_SW; g++) begin : g_lane
            debounce_lane #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .raw         (bus.sw_raw[g]),
                .stable_next (stable_next_s[g]),
                .change      (change_s[g])
            );
        end
    endgenerate

    // Toggles are suppressed until armed so switches already up at power-on never score.
    always_comb begin
        toggle_next_s = '0;
        hit_next_s    = hit_r;
        if (armed_r) begin
            toggle_next_s = change_s;
        end else begin
            toggle_next_s = '0;
        end
        if (bus.clear) begin
            hit_next_s = toggle_next_s;
        end else begin
            hit_next_s = hit_r | toggle_next_s;
        end
    end

    // Arming FSM: wait out synchroniser fill plus one debounce run, then stay in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ARMING;
            arm_cnt_r <= '0;
            armed_r   <= 1'b0;
        end else begin
            case (state_r)
                ARMING: begin
                    arm_cnt_r <= arm_cnt_r + ARM_ONE;
                    if (arm_cnt_r == ARM_LAST) begin
                        state_r <= RUN;
                        armed_r <= 1'b1;
                    end else begin
                        state_r <= ARMING;
                        armed_r <= 1'b0;
                    end
                end
                RUN: begin
                    state_r <= RUN;
                    armed_r <= 1'b1;
                end
                default: begin
                    state_r   <= ARMING;
                    arm_cnt_r <= '0;
                    armed_r   <= 1'b0;
                end
            endcase
        end
    end

    // Registered switch outputs; sw_stable mirrors the lane flops one-for-one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_stable_r <= '0;
            toggle_r    <= '0;
            hit_r       <= '0;
        end else begin
            sw_stable_r <= stable_next_s;
            toggle_r    <= toggle_next_s;
            hit_r       <= hit_next_s;
        end
    end

    assign bus.sw_stable = sw_stable_r;
    assign bus.sw_toggle = toggle_r;
    assign bus.hit_latch = hit_r;
    assign bus.armed     = armed_r;

endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: a window-based reference model
// queues expected outputs per edge; a negedge monitor pops and compares.
module tb_switch_conditioner;
    import whackmole_pkg::*;

    localparam int N = N_MOLES;
    localparam int S = 2;
    localparam int D = 4;

    typedef struct packed {
        mole_vec_t stable;
        mole_vec_t toggle;
        mole_vec_t hit;
        logic      armed;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    switch_conditioner_if #(.N_SW(N)) ifc ();

    switch_conditioner #(
        .N_SW            (N),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int        n_cmp = 0;
    int        n_bad = 0;
    exp_t      exp_q[$];
    mole_vec_t samp[$];
    int        n_edges = 0;
    mole_vec_t m_stable = '0;
    mole_vec_t m_hit = '0;
    mole_vec_t cur_raw = '0;

    task automatic check(input string name, input mole_vec_t act, input mole_vec_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic mole_vec_t ext1(input logic b);
        return {{(N-1){1'b0}}, b};
    endfunction

    // Raw level sampled at the j-th edge after reset; synchroniser holds 0 before that.
    function automatic mole_vec_t s_at(input int j);
        if (j < 1) return '0;
        return samp[j-1];
    endfunction

    // A lane accepts level v when the last D compared samples all equal v and v differs.
    task automatic model_edge(input mole_vec_t raw, input logic clr, input logic rst, output exp_t e);
        mole_vec_t w0, wk, same, chg, tg;
        logic      was_armed;
        if (rst) begin
            samp.delete();
            n_edges  = 0;
            m_stable = '0;
            m_hit    = '0;
            e        = '0;
        end else begin
            was_armed = (n_edges >= S + D);
            n_edges++;
            samp.push_back(raw);
            w0   = s_at(n_edges - S);
            same = '1;
            for (int k = 1; k < D; k++) begin
                wk   = s_at(n_edges - S - k);
                same = same & ~(wk ^ w0);
            end
            chg      = same & (w0 ^ m_stable);
            tg       = was_armed ? chg : '0;
            m_stable = m_stable ^ chg;
            m_hit    = clr ? tg : (m_hit | tg);
            e.stable = m_stable;
            e.toggle = tg;
            e.hit    = m_hit;
            e.armed  = (n_edges >= S + D);
        end
    endtask

    task automatic step(input mole_vec_t raw, input logic clr, input logic rst);
        exp_t e;
        ifc.sw_raw = raw;
        ifc.clear  = clr;
        reset      = rst;
        model_edge(raw, clr, rst, e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: every edge presents a full output word; compare it against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sw_stable", ifc.sw_stable, e.stable);
            check("sw_toggle", ifc.sw_toggle, e.toggle);
            check("hit_latch", ifc.hit_latch, e.hit);
            check("armed", ext1(ifc.armed), ext1(e.armed));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.sw_raw = '0;
        ifc.clear  = 1'b0;
        reset      = 1'b1;

        // Reset with all switches low; armed rises on the sixth edge after release.
        repeat (3) step('0, 1'b0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            step('0, 1'b0, 1'b0);
            check("armed_rise", ext1(ifc.armed), ext1(c >= 6));
        end

        // Lane 3 up through reset: it settles during arming without scoring.
        cur_raw[3] = 1'b1;
        repeat (2) step(cur_raw, 1'b0, 1'b1);
        repeat (8) step(cur_raw, 1'b0, 1'b0);
        check("preset_stable3", ext1(ifc.sw_stable[3]), ext1(1'b1));
        check("preset_nohit", ifc.hit_latch, '0);

        // Clean rise on lane 5: toggle on edge k+5.
        cur_raw[5] = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            step(cur_raw, 1'b0, 1'b0);
            check("tog5_latency", ext1(ifc.sw_toggle[5]), ext1(c == 5));
        end
        check("hit5_held", ext1(ifc.hit_latch[5]), ext1(1'b1));

        // Three-cycle glitch on lane 0 is rejected.
        cur_raw[0] = 1'b1;
        repeat (3) step(cur_raw, 1'b0, 1'b0);
        cur_raw[0] = 1'b0;
        repeat (8) step(cur_raw, 1'b0, 1'b0);
        check("glitch0_stable", ext1(ifc.sw_stable[0]), ext1(1'b0));

        // Bounce on lane 7: count restarts from the last rise.
        cur_raw[7] = 1'b1;
        repeat (3) step(cur_raw, 1'b0, 1'b0);
        cur_raw[7] = 1'b0;
        step(cur_raw, 1'b0, 1'b0);
        cur_raw[7] = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            step(cur_raw, 1'b0, 1'b0);
            check("tog7_bounce", ext1(ifc.sw_toggle[7]), ext1(c == 5));
        end

        // Build hit_latch = 0x00021, then clear coinciding with a lane 17 toggle.
        cur_raw = '0;
        repeat (2) step(cur_raw, 1'b0, 1'b1);
        repeat (8) step(cur_raw, 1'b0, 1'b0);
        cur_raw[0] = 1'b1;
        cur_raw[5] = 1'b1;
        repeat (6) step(cur_raw, 1'b0, 1'b0);
        check("hit_21", ifc.hit_latch, 18'h00021);
        cur_raw[17] = 1'b1;
        for (int c = 0; c <= 5; c++) step(cur_raw, c == 5, 1'b0);
        check("clear_with_toggle", ifc.hit_latch, 18'h20000);
        repeat (2) step(cur_raw, 1'b0, 1'b0);
        step(cur_raw, 1'b1, 1'b0);
        check("clear_alone", ifc.hit_latch, 18'h00000);

        // Reset in the middle of a lane 2 count.
        cur_raw[2] = 1'b1;
        repeat (3) step(cur_raw, 1'b0, 1'b0);
        step(cur_raw, 1'b0, 1'b1);
        check("reset_armed_drop", ext1(ifc.armed), ext1(1'b0));
        check("reset_no_toggle", ifc.sw_toggle, '0);
        repeat (10) step(cur_raw, 1'b0, 1'b0);

        // Randomised bouncing switches, round clears and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) cur_raw[i] = ~cur_raw[i];
            end
            step(cur_raw, $urandom_range(0, 15) == 0, $urandom_range(0, 599) == 0);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", ext1(exp_q.size() == 0), ext1(1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input-side front end for the whack-a-mole game: takes the 18 raw slide switches (the player's "hammers") and turns them into clean, debounced, edge-detected hit information for the game logic. It sits between the board switches and the whacking/scoring logic, the input counterpart of the LED/7-segment output path. It also accumulates hits per round between `clear` pulses, driven by the general game timer tick.

## Interface
- `N_SW`, 18: number of switch lanes.
- `SYNC_STAGES`, 2: synchroniser flops per lane (≥2).
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz; ≥1).

Ports:
- `clk`  in  1: system clock (50 MHz); the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `sw_raw`  in  N_SW: asynchronous raw switch levels.
- `clear`  in  1: one-cycle round boundary; clears `hit_latch`.
- `sw_stable`  out  N_SW: debounced switch levels.
- `sw_toggle`  out  N_SW: one-cycle pulse per lane when `sw_stable` changes (either direction) while armed.
- `hit_latch`  out  N_SW: sticky per-lane "toggled since last clear".
- `armed`  out  1: high once the post-reset settle window has elapsed.

## Operation
- Per lane: `SYNC_STAGES`-deep synchroniser feeds a debounce counter `cnt` (width clog2(DEBOUNCE_CYCLES+1)).
- Debounce rule, every cycle: if `sync != sw_stable`, increment `cnt`. When `cnt == DEBOUNCE_CYCLES-1` and the lane still differs, load `sw_stable <= sync` and reset `cnt <= 0`. If `sync == sw_stable`, reset `cnt <= 0`. Any bounce back therefore restarts the count.
- Toggle: `sw_toggle[i]` is registered high in the same cycle `sw_stable[i]` changes, only if `armed` is high. It is low otherwise.
- Arming FSM, two states:
  - ARMING (reset state): counter `arm_cnt` counts up to SYNC_STAGES+DEBOUNCE_CYCLES; then go to RUN.
  - RUN: `armed = 1`; terminal until reset.
  - During ARMING, `sw_stable` tracks the switches normally but no toggles or hits are produced. This prevents switches that are already up at power-on from scoring.
- Hit latch: `hit_latch[i]` sets on `sw_toggle[i]` and holds until `clear`.
  - `clear` with a simultaneous toggle: `hit_latch <= sw_toggle_next`. The new round keeps that hit and the old hits are dropped.
- Lanes are fully independent; any number may toggle in the same cycle.

## Timing
- Reset values: `sw_stable = 0`, `sw_toggle = 0`, `hit_latch = 0`, `armed = 0`, all sync flops, `cnt` and `arm_cnt` = 0, FSM in ARMING.
- Reset mid-operation discards pending counts and latched hits. Re-arming takes the full window again.
- Latency: a clean level change first sampled at edge k appears on `sw_stable` and `sw_toggle` after edge k + SYNC_STAGES + DEBOUNCE_CYCLES − 1.
- A glitch shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produces no output change.
- `armed` rises exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles after reset deasserts.
- `hit_latch` updates on the same edge as `sw_toggle`, so no extra latency is added.
- `clear` takes effect on the next edge; it may be held high, in which case `hit_latch` shows only the current-cycle toggles.

## Structure
- Shared package `whackmole_pkg`: `N_MOLES = 18`, `DEBOUNCE_20MS = 1_000_000`, and the `mole_vec_t` typedef (logic [N_MOLES-1:0]), reused by the rng, whacking and scoring blocks.
- Sub-module `debounce_lane`: contains one synchroniser, counter and stable flop, and outputs `stable_next`/`change`. It is instantiated N_SW times with a generate loop.
- The arming FSM and the hit latch stay in `switch_conditioner`.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
- Reset, all `sw_raw` = 0:
  - During reset, all outputs are 0.
  - `armed` rises 6 cycles after reset release.
  - No pulses.
- Before reset, set `sw_raw[3]` = 1 and hold through release:
  - `sw_stable[3]` goes to 1 during ARMING.
  - `sw_toggle` and `hit_latch` stay 0.
- After arming, set `sw_raw[5]` 0→1 first sampled at edge k:
  - `sw_stable[5]` = 1 and a one-cycle `sw_toggle[5]` after edge k+5.
  - `hit_latch[5]` = 1 and held.
- After arming, pulse `sw_raw[0]` high for 3 cycles:
  - No change on any output.
- Pulse `sw_raw[7]` high for 3 cycles, low 1 cycle, then hold high:
  - Toggle occurs only after 4 consecutive synchronised high cycles, measured from the last rise.
- With `hit_latch` = 18'h00021:
  - `clear` in the same cycle as a `sw_toggle[17]` gives `hit_latch` = 18'h20000.
  - A later `clear` alone gives 0.
  - Assert `reset` mid-count on lane 2: no toggle, and `armed` drops to 0.
